// File: rtl/traffic_light_controller_if.sv
// Timer handshake between the intersection controller (master) and the 1 Hz countdown timer (slave).
interface traffic_light_controller_if;
  logic       start_timer;
  logic [4:0] value;
  logic       expired;

  modport master (output start_timer, output value, input expired);
  modport slave  (input start_timer, input value, output expired);
endinterface

// File: rtl/traffic_light_controller.sv
// Two-road intersection sequencer with a pedestrian walk phase and run-time programmable intervals.
// Drives an external countdown timer: a start pulse on every state entry, then waits on expired.
module traffic_light_controller #(
  parameter logic [3:0] T_BASE_DEF = 4'd6,
  parameter logic [3:0] T_EXT_DEF  = 4'd3,
  parameter logic [3:0] T_YEL_DEF  = 4'd2
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              sensor,
  input  logic                              walk_request,
  input  logic                              reprogram,
  input  logic [1:0]                        prog_sel,
  input  logic [3:0]                        prog_value,
  traffic_light_controller_if.master        timer,
  output logic [2:0]                        main_lights,
  output logic [2:0]                        side_lights,
  output logic                              walk_lamp,
  output logic [2:0]                        state_dbg
);

  typedef enum logic [2:0] {
    MG  = 3'd0,
    MY  = 3'd1,
    WK  = 3'd2,
    SG  = 3'd3,
    SGX = 3'd4,
    SY  = 3'd5
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [1:0] age;
  logic       restart;
  logic       entry;
  logic       settled;
  logic [3:0] t_base;
  logic [3:0] t_ext;
  logic [3:0] t_yel;
  logic [3:0] interval;
  logic       walk_pending;
  logic       prog_write;
  logic [3:0] prog_clamped;

  assign prog_write   = reprogram && (prog_sel != 2'b11);
  assign prog_clamped = (prog_value == 4'd0) ? 4'd1 : prog_value;

  // age counts cycles since state entry: 0 = entry (pulse), 1 = timer loading, 2 = expired valid
  assign entry   = (age == 2'd0);
  assign settled = (age == 2'd2);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= MG;
      age   <= 2'd0;
    end else begin
      state <= next_state;
      if (restart)
        age <= 2'd0;
      else if (!settled)
        age <= age + 2'd1;
    end
  end

  always_comb begin
    next_state = state;
    restart    = 1'b0;
    if (prog_write) begin
      next_state = MG;
      restart    = 1'b1;
    end else if (settled && timer.expired) begin
      case (state)
        MG:      next_state = (sensor || walk_pending) ? MY : MG;
        MY:      next_state = walk_pending ? WK : SG;
        WK:      next_state = SG;
        SG:      next_state = sensor ? SGX : SY;
        SGX:     next_state = SY;
        SY:      next_state = MG;
        default: next_state = MG;
      endcase
      restart = (next_state != state);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      t_base       <= T_BASE_DEF;
      t_ext        <= T_EXT_DEF;
      t_yel        <= T_YEL_DEF;
      walk_pending <= 1'b0;
    end else begin
      // A request in the walk entry cycle survives the clear so it is served next round
      walk_pending <= walk_request || (walk_pending && !(entry && state == WK));
      if (prog_write) begin
        case (prog_sel)
          2'b00:   t_base <= prog_clamped;
          2'b01:   t_ext  <= prog_clamped;
          2'b10:   t_yel  <= prog_clamped;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    interval    = t_base;
    main_lights = 3'b100;
    side_lights = 3'b100;
    walk_lamp   = 1'b0;
    case (state)
      MG: begin
        interval    = t_base;
        main_lights = 3'b001;
      end
      MY: begin
        interval    = t_yel;
        main_lights = 3'b010;
      end
      WK: begin
        interval  = t_ext;
        walk_lamp = 1'b1;
      end
      SG: begin
        interval    = t_base;
        side_lights = 3'b001;
      end
      SGX: begin
        interval    = t_ext;
        side_lights = 3'b001;
      end
      SY: begin
        interval    = t_yel;
        side_lights = 3'b010;
      end
      default: ;
    endcase
  end

  assign timer.start_timer = entry && !reset;
  assign timer.value       = timer.start_timer ? {1'b0, interval} : 5'd0;
  assign state_dbg         = state;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench for traffic_light_controller: sequencing, walk phase, reprogramming and reset recovery.
module tb_traffic_light_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       sensor;
  logic       walk_request;
  logic       reprogram;
  logic [1:0] prog_sel;
  logic [3:0] prog_value;
  logic [2:0] main_lights;
  logic [2:0] side_lights;
  logic       walk_lamp;
  logic [2:0] state_dbg;
  int         total = 0;
  int         bad = 0;
  int         pulses;

  traffic_light_controller_if tl_if ();

  traffic_light_controller dut (
    .clock        (clock),
    .reset        (reset),
    .sensor       (sensor),
    .walk_request (walk_request),
    .reprogram    (reprogram),
    .prog_sel     (prog_sel),
    .prog_value   (prog_value),
    .timer        (tl_if.master),
    .main_lights  (main_lights),
    .side_lights  (side_lights),
    .walk_lamp    (walk_lamp),
    .state_dbg    (state_dbg)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_lights(input string tag, input logic [2:0] m, input logic [2:0] s, input logic w);
    check_output({tag, " main"}, main_lights, m);
    check_output({tag, " side"}, side_lights, s);
    check_output({tag, " walk"}, walk_lamp, w);
  endtask

  // From a state's entry cycle with expired held high: two ignored cycles, then the move
  task automatic advance(input string tag, input logic [2:0] from_st, input logic [2:0] to_st,
                         input logic [4:0] val);
    tl_if.expired = 1'b1;
    step();
    check_output({tag, " hold1 state"}, state_dbg, from_st);
    check_output({tag, " hold1 start"}, tl_if.start_timer, 1'b0);
    step();
    check_output({tag, " hold2 state"}, state_dbg, from_st);
    step();
    check_output({tag, " state"}, state_dbg, to_st);
    check_output({tag, " start"}, tl_if.start_timer, 1'b1);
    check_output({tag, " value"}, tl_if.value, val);
  endtask

  initial begin
    reset = 1'b1; sensor = 1'b0; walk_request = 1'b0; reprogram = 1'b0;
    prog_sel = 2'b00; prog_value = 4'd0; tl_if.expired = 1'b0;

    // 1: reset state, then idle MG with no demand
    step();
    check_output("rst state", state_dbg, 3'd0);
    check_output("rst start", tl_if.start_timer, 1'b0);
    check_output("rst value", tl_if.value, 5'd0);
    check_lights("rst", 3'b001, 3'b100, 1'b0);
    reset = 1'b0;
    #1;
    check_output("t1 start", tl_if.start_timer, 1'b1);
    check_output("t1 value", tl_if.value, 5'd6);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tl_if.expired = (i >= 5);
      step();
      if (tl_if.start_timer) pulses++;
    end
    check_output("t1 state", state_dbg, 3'd0);
    check_output("t1 pulses", pulses, 0);
    check_lights("t1", 3'b001, 3'b100, 1'b0);

    // 2: full side cycle with one extension only
    sensor = 1'b1;
    step();
    check_output("t2 MY state", state_dbg, 3'd1);
    check_output("t2 MY value", tl_if.value, 5'd2);
    check_lights("t2 MY", 3'b010, 3'b100, 1'b0);
    advance("t2 MY>SG", 3'd1, 3'd3, 5'd6);
    check_lights("t2 SG", 3'b100, 3'b001, 1'b0);
    advance("t2 SG>SGX", 3'd3, 3'd4, 5'd3);
    advance("t2 SGX>SY", 3'd4, 3'd5, 5'd2);
    check_lights("t2 SY", 3'b100, 3'b010, 1'b0);
    advance("t2 SY>MG", 3'd5, 3'd0, 5'd6);

    // 3: walk request during SG is served after the next main green
    advance("t3 MG>MY", 3'd0, 3'd1, 5'd2);
    advance("t3 MY>SG", 3'd1, 3'd3, 5'd6);
    sensor = 1'b0;
    walk_request = 1'b1;
    tl_if.expired = 1'b0;
    step();
    walk_request = 1'b0;
    step();
    tl_if.expired = 1'b1;
    step();
    check_output("t3 SG>SY state", state_dbg, 3'd5);
    advance("t3 SY>MG", 3'd5, 3'd0, 5'd6);
    advance("t3 MG>MY", 3'd0, 3'd1, 5'd2);
    advance("t3 MY>WK", 3'd1, 3'd2, 5'd3);
    check_lights("t3 WK", 3'b100, 3'b100, 1'b1);
    advance("t3 WK>SG", 3'd2, 3'd3, 5'd6);
    advance("t3 SG>SY", 3'd3, 3'd5, 5'd2);
    advance("t3 SY>MG", 3'd5, 3'd0, 5'd6);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (tl_if.start_timer) pulses++;
    end
    check_output("t3 no walk state", state_dbg, 3'd0);
    check_output("t3 no walk pulses", pulses, 0);

    // 4: reprogram base in SY, then yellow with zero clamped to 1
    sensor = 1'b1;
    step();
    check_output("t4 MY state", state_dbg, 3'd1);
    sensor = 1'b0;
    advance("t4 MY>SG", 3'd1, 3'd3, 5'd6);
    advance("t4 SG>SY", 3'd3, 3'd5, 5'd2);
    reprogram = 1'b1; prog_sel = 2'b00; prog_value = 4'd9;
    step();
    check_output("t4 base state", state_dbg, 3'd0);
    check_output("t4 base start", tl_if.start_timer, 1'b1);
    check_output("t4 base value", tl_if.value, 5'd9);
    prog_sel = 2'b10; prog_value = 4'd0;
    step();
    check_output("t4 yel start", tl_if.start_timer, 1'b1);
    reprogram = 1'b0;
    sensor = 1'b1;
    advance("t4 MG>MY", 3'd0, 3'd1, 5'd1);
    sensor = 1'b0;

    // 5: reprogram beats expiry in SG; prog_sel=11 is ignored
    advance("t5 MY>SG", 3'd1, 3'd3, 5'd9);
    step();
    step();
    reprogram = 1'b1; prog_sel = 2'b01; prog_value = 4'd5;
    step();
    check_output("t5 prio state", state_dbg, 3'd0);
    check_output("t5 prio value", tl_if.value, 5'd9);
    prog_sel = 2'b11; prog_value = 4'd7;
    step();
    check_output("t5 sel11 state", state_dbg, 3'd0);
    check_output("t5 sel11 start", tl_if.start_timer, 1'b0);

    // 6: reset in WK restores defaults and drops the pending walk
    reprogram = 1'b0;
    walk_request = 1'b1;
    tl_if.expired = 1'b0;
    step();
    walk_request = 1'b0;
    tl_if.expired = 1'b1;
    step();
    check_output("t6 MY state", state_dbg, 3'd1);
    advance("t6 MY>WK", 3'd1, 3'd2, 5'd5);
    walk_request = 1'b1;
    step();
    walk_request = 1'b0;
    reset = 1'b1;
    step();
    check_output("t6 rst state", state_dbg, 3'd0);
    check_output("t6 rst start", tl_if.start_timer, 1'b0);
    check_lights("t6 rst", 3'b001, 3'b100, 1'b0);
    reset = 1'b0;
    #1;
    check_output("t6 start", tl_if.start_timer, 1'b1);
    check_output("t6 value", tl_if.value, 5'd6);
    sensor = 1'b1;
    advance("t6 MG>MY", 3'd0, 3'd1, 5'd2);
    advance("t6 MY>SG", 3'd1, 3'd3, 5'd6);
    advance("t6 SG>SGX", 3'd3, 3'd4, 5'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
